// File: rtl/menu_input_pkg.sv
// menu_pkg: shared encodings for the menu front end and the screen/level state machine.
// Contents: 4-bit screen state type, screen codes (SM/LS/GO), level codes L1..L8,
// and the default number of selectable levels.
package menu_pkg;

  typedef logic [3:0] state_t;

  // Screen encodings
  localparam state_t SM = 4'b1111;
  localparam state_t LS = 4'b0001;
  localparam state_t GO = 4'b0010;

  // Level encodings used by the state machine
  localparam state_t L1 = 4'b0011;
  localparam state_t L2 = 4'b0100;
  localparam state_t L3 = 4'b0101;
  localparam state_t L4 = 4'b0110;
  localparam state_t L5 = 4'b0111;
  localparam state_t L6 = 4'b1000;
  localparam state_t L7 = 4'b1001;
  localparam state_t L8 = 4'b1010;

  localparam int NUM_LEVELS_DEF = 8;

endpackage

// File: rtl/menu_input_btn_debounce.sv
// btn_debounce: conditions one raw push-button into a debounced level and a one-cycle press pulse.
// Ports: clk, rst (sync, active high), raw (async button) -> level (debounced value),
//        press (one-cycle pulse on an accepted 0->1 change, DEBOUNCE_CYCLES+3 cycles after raw is first sampled high).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      // Registered rising edge of the debounced value; releases never pulse.
      press <= deb & ~deb_q;
      // The counter only runs while the synced input disagrees with the
      // accepted value, so any bounce back resets the stability window.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = deb;

endmodule

// File: rtl/menu_input.sv
// menu_input: turns four raw buttons into cursor motion, a level request and a start request.
// Ports: clk, rst (sync, active high), btn_up/btn_down/btn_sel/btn_start (raw async buttons),
//        cur_state (screen state) -> level_out (one-cycle level 1..NUM_LEVELS, else 0),
//        start_pulse (one-cycle start/continue), cursor (highlighted level 1..NUM_LEVELS).
// Optional: define MENU_INPUT_AUTOREPEAT_EN for hold-to-repeat on up/down while in LS.
module menu_input
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_LEVELS      = NUM_LEVELS_DEF,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 15000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       btn_start,
  input  logic [3:0] cur_state,
  output logic [3:0] level_out,
  output logic       start_pulse,
  output logic [3:0] cursor
);

  localparam logic [3:0] NL = 4'(NUM_LEVELS);

  logic up_press;
  logic dn_press;
  logic sel_press;
  logic start_press;
  logic up_lvl;
  logic dn_lvl;
  logic in_ls;
  logic up_ev;
  logic dn_ev;

  assign in_ls = (cur_state == LS);

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .raw(btn_up), .level(up_lvl), .press(up_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .raw(btn_down), .level(dn_lvl), .press(dn_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .rst(rst), .raw(btn_sel), .level(), .press(sel_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .raw(btn_start), .level(), .press(start_press)
  );

`ifdef MENU_INPUT_AUTOREPEAT_EN
  // Index 0 = up, 1 = down.
  logic [1:0]  hold_lvl;
  logic [1:0]  first_pr;
  logic [1:0]  rpt_phase;
  logic [1:0]  rpt_fire;
  logic [31:0] rpt_cnt [2];

  assign hold_lvl = {dn_lvl, up_lvl};
  assign first_pr = {dn_press, up_press};

  // Counter reads 0 in the cycle after the physical press, so matching
  // HOLD_CYCLES-1 fires exactly HOLD_CYCLES cycles after it; afterwards the
  // period switches to REPEAT_CYCLES.
  always_comb begin
    rpt_fire = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (hold_lvl[i] && in_ls && !first_pr[i]) begin
        if (rpt_phase[i])
          rpt_fire[i] = (rpt_cnt[i] == 32'(REPEAT_CYCLES - 1));
        else
          rpt_fire[i] = (rpt_cnt[i] == 32'(HOLD_CYCLES - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || !hold_lvl[i] || !in_ls || first_pr[i]) begin
        rpt_cnt[i]   <= '0;
        rpt_phase[i] <= 1'b0;
      end else if (rpt_fire[i]) begin
        rpt_cnt[i]   <= '0;
        rpt_phase[i] <= 1'b1;
      end else begin
        rpt_cnt[i]   <= rpt_cnt[i] + 32'd1;
      end
    end
  end

  assign up_ev = up_press | rpt_fire[0];
  assign dn_ev = dn_press | rpt_fire[1];
`else
  assign up_ev = up_press;
  assign dn_ev = dn_press;

  // HOLD_CYCLES/REPEAT_CYCLES only shape the autorepeat build; this empty
  // block just keeps them referenced.
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_rpt_cfg_unused
  end

  logic unused_lvls;
  assign unused_lvls = up_lvl ^ dn_lvl;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cursor      <= 4'd1;
      level_out   <= 4'd0;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= start_press;
      // Samples the pre-move cursor, so sel together with up/down reports
      // the level highlighted before the step.
      level_out   <= (sel_press && in_ls) ? cursor : 4'd0;
      if (in_ls) begin
        // Simultaneous up and down cancel out.
        if (up_ev && !dn_ev)
          cursor <= (cursor >= NL) ? 4'd1 : cursor + 4'd1;
        else if (dn_ev && !up_ev)
          cursor <= (cursor <= 4'd1) ? NL : cursor - 4'd1;
      end
    end
  end

endmodule
